// File: rtl/hsv_core_branch_pipe.sv
// Branch/jump resolution pipeline.
// Stage 1 resolves the branch condition and computes the target, stage 2
// forms the commit fields (next PC, link value, mispredict, misalignment),
// and a small in-order FIFO decouples the pipe from the commit handshake.
// Input acceptance is credit based: a beat is only taken when the FIFO is
// guaranteed to have room for it and everything already in the stages.
module hsv_core_branch_pipe #(
   parameter int XLEN   = 32,
   parameter int TAG_W  = 6,
   parameter int DEPTH  = 4,
   parameter int ALIGN4 = 1
) (
   input  logic             clk_core,
   input  logic             rst_core,
   input  logic             flush_req,
   output logic             flush_ack,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_pred_taken,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [TAG_W-1:0] out_tag,
   output logic [XLEN-1:0]  out_link,
   output logic [XLEN-1:0]  out_next_pc,
   output logic             out_mispredict,
   output logic             out_exc_misaligned
);

   localparam logic [2:0] OP_BEQ  = 3'd0;
   localparam logic [2:0] OP_BNE  = 3'd1;
   localparam logic [2:0] OP_JAL  = 3'd2;
   localparam logic [2:0] OP_JALR = 3'd3;
   localparam logic [2:0] OP_BLT  = 3'd4;
   localparam logic [2:0] OP_BGE  = 3'd5;
   localparam logic [2:0] OP_BLTU = 3'd6;
   localparam logic [2:0] OP_BGEU = 3'd7;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 2;
   localparam int ENT_W = TAG_W + 2 * XLEN + 2;

   // ---------------- input handshake ----------------
   logic             accept;
   logic [PTR_W:0]   fifo_count_reg;
   logic [PTR_W:0]   fifo_count_next;
   logic             s1_valid_reg;
   logic             s2_valid_reg;
   logic [CNT_W-1:0] in_flight;

   // Count every beat that will eventually land in the FIFO; ignoring pops
   // keeps this conservative so a push can never find the FIFO full.
   assign in_flight = CNT_W'(fifo_count_reg) + CNT_W'(s1_valid_reg) + CNT_W'(s2_valid_reg);
   assign ready_o   = !rst_core && !flush_req && (in_flight < CNT_W'(DEPTH));
   assign accept    = valid_i && ready_o;

   // ---------------- stage 1: condition and target ----------------
   logic            cond_taken;
   logic [XLEN-1:0] sum_pc_imm;
   logic [XLEN-1:0] sum_rs1_imm;
   logic [XLEN-1:0] target_calc;

   assign sum_pc_imm  = in_pc + in_imm;
   assign sum_rs1_imm = in_rs1 + in_imm;
   // JALR targets drop bit 0 so they are always at least halfword aligned.
   assign target_calc = (in_op == OP_JALR) ? {sum_rs1_imm[XLEN-1:1], 1'b0} : sum_pc_imm;

   // Decode the branch condition from the operands.
   always_comb begin
      cond_taken = 1'b0;
      case (in_op)
         OP_BEQ:  cond_taken = (in_rs1 == in_rs2);
         OP_BNE:  cond_taken = (in_rs1 != in_rs2);
         OP_JAL:  cond_taken = 1'b1;
         OP_JALR: cond_taken = 1'b1;
         OP_BLT:  cond_taken = ($signed(in_rs1) <  $signed(in_rs2));
         OP_BGE:  cond_taken = ($signed(in_rs1) >= $signed(in_rs2));
         OP_BLTU: cond_taken = (in_rs1 <  in_rs2);
         OP_BGEU: cond_taken = (in_rs1 >= in_rs2);
         default: cond_taken = 1'b0;
      endcase
   end

   logic             s1_taken_reg;
   logic [XLEN-1:0]  s1_target_reg;
   logic [XLEN-1:0]  s1_pc_reg;
   logic             s1_is_jump_reg;
   logic [TAG_W-1:0] s1_tag_reg;
   logic             s1_pred_reg;

   // Stage 1 register: valid is cleared by reset/flush, payload loads on accept.
   always_ff @(posedge clk_core) begin
      if (rst_core || flush_req) begin
         s1_valid_reg <= 1'b0;
      end else begin
         s1_valid_reg <= accept;
      end
      if (accept) begin
         s1_taken_reg   <= cond_taken;
         s1_target_reg  <= target_calc;
         s1_pc_reg      <= in_pc;
         s1_is_jump_reg <= (in_op == OP_JAL) || (in_op == OP_JALR);
         s1_tag_reg     <= in_tag;
         s1_pred_reg    <= in_pred_taken;
      end
   end

   // ---------------- stage 2: commit fields ----------------
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] next_pc_calc;
   logic [XLEN-1:0] link_calc;
   logic            exc_calc;
   logic            mispredict_calc;

   assign seq_pc       = s1_pc_reg + XLEN'(4);
   assign next_pc_calc = s1_taken_reg ? s1_target_reg : seq_pc;
   assign link_calc    = s1_is_jump_reg ? seq_pc : '0;
   assign exc_calc     = s1_taken_reg && ((ALIGN4 != 0) ? s1_target_reg[1] : s1_target_reg[0]);
   // A misaligned target traps instead of redirecting, so it never mispredicts.
   assign mispredict_calc = !exc_calc && (s1_taken_reg != s1_pred_reg);

   logic [TAG_W-1:0] s2_tag_reg;
   logic [XLEN-1:0]  s2_link_reg;
   logic [XLEN-1:0]  s2_next_pc_reg;
   logic             s2_mispredict_reg;
   logic             s2_exc_reg;

   // Stage 2 register: always advances from stage 1.
   always_ff @(posedge clk_core) begin
      if (rst_core || flush_req) begin
         s2_valid_reg <= 1'b0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
      end
      if (s1_valid_reg) begin
         s2_tag_reg        <= s1_tag_reg;
         s2_link_reg       <= link_calc;
         s2_next_pc_reg    <= next_pc_calc;
         s2_mispredict_reg <= mispredict_calc;
         s2_exc_reg        <= exc_calc;
      end
   end

   // ---------------- output FIFO ----------------
   logic [ENT_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic             push;
   logic             pop;
   logic [ENT_W-1:0] head;

   assign push    = s2_valid_reg;
   assign valid_o = (fifo_count_reg != '0);
   assign pop     = valid_o && ready_i;

   // Occupancy update; push and pop together leave the count unchanged.
   always_comb begin
      fifo_count_next = fifo_count_reg;
      case ({push, pop})
         2'b10:   fifo_count_next = fifo_count_reg + (PTR_W + 1)'(1);
         2'b01:   fifo_count_next = fifo_count_reg - (PTR_W + 1)'(1);
         default: fifo_count_next = fifo_count_reg;
      endcase
   end

   // Pointer and count state; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge clk_core) begin
      if (rst_core || flush_req) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         fifo_count_reg <= fifo_count_next;
      end
   end

   // Storage write; the head entry is never overwritten while it is presented.
   always_ff @(posedge clk_core) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {s2_tag_reg, s2_link_reg, s2_next_pc_reg,
                                  s2_mispredict_reg, s2_exc_reg};
      end
   end

   assign head = fifo_mem[rd_ptr_reg];
   assign {out_tag, out_link, out_next_pc, out_mispredict, out_exc_misaligned} = head;

   // ---------------- flush acknowledge ----------------
   logic flush_ack_reg;

   // Acknowledge one cycle after the flush request; held high through reset.
   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         flush_ack_reg <= 1'b1;
      end else begin
         flush_ack_reg <= flush_req;
      end
   end

   assign flush_ack = flush_ack_reg;

endmodule

// File: tb/tb_hsv_core_branch_pipe.sv
// Scoreboard bench for hsv_core_branch_pipe: two instances (4-byte and
// 2-byte alignment) see identical stimulus and are compared to a reference model.
module tb_hsv_core_branch_pipe;
   localparam int XLEN  = 32;
   localparam int TAG_W = 6;
   localparam int DEPTH = 4;

   logic clk_core = 1'b0;
   always #5 clk_core = ~clk_core;

   logic             rst_core, flush_req, valid_i, ready_i, in_pred_taken;
   logic [2:0]       in_op;
   logic [XLEN-1:0]  in_pc, in_rs1, in_rs2, in_imm;
   logic [TAG_W-1:0] in_tag;
   logic             flush_ack, ready_o, valid_o, out_mispredict, out_exc_misaligned;
   logic [TAG_W-1:0] out_tag;
   logic [XLEN-1:0]  out_link, out_next_pc;
   logic             flush_ack_b, ready_o_b, valid_o_b, out_mispredict_b, out_exc_misaligned_b;
   logic [TAG_W-1:0] out_tag_b;
   logic [XLEN-1:0]  out_link_b, out_next_pc_b;

   hsv_core_branch_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .ALIGN4(1)) dut_a (
      .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req), .flush_ack(flush_ack),
      .valid_i(valid_i), .ready_o(ready_o), .in_op(in_op), .in_pc(in_pc), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag), .in_pred_taken(in_pred_taken),
      .valid_o(valid_o), .ready_i(ready_i), .out_tag(out_tag), .out_link(out_link),
      .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
      .out_exc_misaligned(out_exc_misaligned));

   hsv_core_branch_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .ALIGN4(0)) dut_b (
      .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req), .flush_ack(flush_ack_b),
      .valid_i(valid_i), .ready_o(ready_o_b), .in_op(in_op), .in_pc(in_pc), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag), .in_pred_taken(in_pred_taken),
      .valid_o(valid_o_b), .ready_i(ready_i), .out_tag(out_tag_b), .out_link(out_link_b),
      .out_next_pc(out_next_pc_b), .out_mispredict(out_mispredict_b),
      .out_exc_misaligned(out_exc_misaligned_b));

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  link;
      logic [XLEN-1:0]  npc;
      logic             misp;
      logic             exc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   err_cnt = 0;
   int   chk_cnt = 0;
   int   ready_mode = 1;     // 0: hold ready_i low, 1: high, 2: random
   logic [TAG_W-1:0] next_tag = '0;

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   // Reference model of one instruction's commit fields.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm, input logic pred,
                                  input int align4, input logic [TAG_W-1:0] tag);
      exp_t e;
      logic taken;
      logic [31:0] tgt, seq;
      case (op)
         3'd0: taken = (rs1 == rs2);
         3'd1: taken = (rs1 != rs2);
         3'd2, 3'd3: taken = 1'b1;
         3'd4: taken = ($signed(rs1) < $signed(rs2));
         3'd5: taken = !($signed(rs1) < $signed(rs2));
         3'd6: taken = (rs1 < rs2);
         default: taken = !(rs1 < rs2);
      endcase
      tgt = (op == 3'd3) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      seq = pc + 32'd4;
      e.tag  = tag;
      e.npc  = taken ? tgt : seq;
      e.link = (op == 3'd2 || op == 3'd3) ? seq : 32'd0;
      e.exc  = taken && ((align4 != 0) ? tgt[1] : tgt[0]);
      e.misp = e.exc ? 1'b0 : (taken != pred);
      return e;
   endfunction

   // Commit-side ready generator.
   initial begin
      ready_i = 1'b0;
      forever begin
         @(posedge clk_core); #1;
         case (ready_mode)
            0:       ready_i = 1'b0;
            1:       ready_i = 1'b1;
            default: ready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor: scoreboard compare, stall stability, and full-push guard.
   initial begin
      exp_t e;
      exp_t obs_a, obs_b, hold_a, hold_b;
      logic stall_a = 1'b0, stall_b = 1'b0;
      forever begin
         @(negedge clk_core);
         obs_a = {out_tag, out_link, out_next_pc, out_mispredict, out_exc_misaligned};
         obs_b = {out_tag_b, out_link_b, out_next_pc_b, out_mispredict_b, out_exc_misaligned_b};
         if (rst_core) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
         end else begin
            if (dut_a.s2_valid_reg) check_val("push_full", dut_a.fifo_count_reg == DEPTH, 1'b0);
            if (stall_a && valid_o) check_val("stable_a", obs_a, hold_a);
            if (stall_b && valid_o_b) check_val("stable_b", obs_b, hold_b);
            if (valid_o && ready_i) begin
               if (q_a.size() == 0) check_val("spurious_a", valid_o, 1'b0);
               else begin
                  e = q_a.pop_front();
                  check_val("tag_a", out_tag, e.tag);
                  check_val("npc_a", out_next_pc, e.npc);
                  check_val("link_a", out_link, e.link);
                  check_val("misp_a", out_mispredict, e.misp);
                  check_val("exc_a", out_exc_misaligned, e.exc);
               end
            end
            if (valid_o_b && ready_i) begin
               if (q_b.size() == 0) check_val("spurious_b", valid_o_b, 1'b0);
               else begin
                  e = q_b.pop_front();
                  check_val("beat_b", obs_b, e);
               end
            end
            stall_a = valid_o && !ready_i;
            stall_b = valid_o_b && !ready_i;
            hold_a  = obs_a;
            hold_b  = obs_b;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_core);
      #1;
   endtask

   task automatic set_beat(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] imm, input logic pred);
      in_op = op; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_pred_taken = pred; in_tag = next_tag; valid_i = 1'b1;
   endtask

   task automatic push_exp();
      q_a.push_back(model(in_op, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken, 1, in_tag));
      q_b.push_back(model(in_op, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken, 0, in_tag));
      $display("beat tag=%0d op=%0d pc=%h rs1=%h rs2=%h imm=%h pred=%0d",
               in_tag, in_op, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken);
      next_tag++;
   endtask

   // Offer one beat and hold it until accepted (bounded).
   task automatic drive(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic pred);
      bit done = 1'b0;
      set_beat(op, pc, rs1, rs2, imm, pred);
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk_core);
         if (ready_o) begin
            push_exp();
            done = 1'b1;
         end
         tick(1);
      end
      if (!done) check_val("send_timeout", done, 1'b1);
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 300 && (q_a.size() != 0 || q_b.size() != 0); c++) tick(1);
      check_val("drain_a", q_a.size(), 0);
      check_val("drain_b", q_b.size(), 0);
   endtask

   initial begin
      int acc;
      logic [31:0] vals [5];
      rst_core = 1'b1; flush_req = 1'b0; valid_i = 1'b0;
      in_op = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      in_tag = '0; in_pred_taken = 1'b0;
      vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'd5; vals[3] = 32'hFFFF_FFFF; vals[4] = 32'h8000_0000;

      // Reset state
      tick(3);
      @(negedge clk_core);
      check_val("rst_ready", ready_o, 1'b0);
      check_val("rst_ready_b", ready_o_b, 1'b0);
      check_val("rst_valid", valid_o, 1'b0);
      check_val("rst_ack", flush_ack, 1'b1);
      check_val("rst_ack_b", flush_ack_b, 1'b1);
      tick(1);
      rst_core = 1'b0;
      @(negedge clk_core);
      check_val("post_rst_ready", ready_o, 1'b1);
      check_val("post_rst_valid", valid_o, 1'b0);
      tick(1);

      // BEQ taken, predicted not taken, with latency check
      set_beat(3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
      @(negedge clk_core);
      check_val("beq_ready", ready_o, 1'b1);
      push_exp();
      tick(1);
      valid_i = 1'b0;
      @(negedge clk_core);
      check_val("lat_n0", valid_o, 1'b0);
      @(negedge clk_core);
      check_val("lat_n1", valid_o, 1'b0);
      @(negedge clk_core);
      check_val("lat_n2", valid_o, 1'b1);
      check_val("beq_npc", out_next_pc, 32'h120);
      check_val("beq_misp", out_mispredict, 1'b1);
      check_val("beq_link", out_link, 32'd0);
      check_val("beq_exc", out_exc_misaligned, 1'b0);
      tick(1);
      wait_drain();

      // JALR misaligned (trap only with 4-byte alignment), signed/unsigned compares, PC wrap
      drive(3'd3, 32'h80, 32'h1003, 32'd0, 32'd0, 1'b0);
      drive(3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
      drive(3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
      drive(3'd6, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
      drive(3'd2, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 1'b1);
      valid_i = 1'b0;
      wait_drain();

      // Random mix under random backpressure
      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
         drive(3'($urandom_range(0, 7)), $urandom() & 32'hFFFF_FFFE,
               vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)],
               32'($signed($urandom_range(0, 255)) - 128), 1'($urandom_range(0, 1)));
      end
      valid_i = 1'b0;
      ready_mode = 1;
      wait_drain();

      // Credit backpressure: exactly DEPTH beats accepted with commit stalled
      ready_mode = 0;
      tick(2);
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         set_beat(3'd2, 32'(c * 4), 32'd0, 32'd0, 32'h10, 1'b1);
         @(negedge clk_core);
         if (ready_o) begin
            push_exp();
            acc++;
         end
         tick(1);
      end
      @(negedge clk_core);
      check_val("bp_accepted", acc, DEPTH);
      check_val("bp_ready", ready_o, 1'b0);
      check_val("bp_valid", valid_o, 1'b1);
      tick(1);
      valid_i = 1'b0;
      ready_mode = 1;
      wait_drain();

      // Flush with three beats in flight; the beat offered during flush is dropped
      ready_mode = 0;
      tick(2);
      drive(3'd1, 32'h300, 32'd1, 32'd2, 32'h10, 1'b1);
      drive(3'd1, 32'h304, 32'd1, 32'd2, 32'h10, 1'b1);
      drive(3'd1, 32'h308, 32'd1, 32'd2, 32'h10, 1'b1);
      set_beat(3'd2, 32'h30C, 32'd0, 32'd0, 32'h10, 1'b1);
      flush_req = 1'b1;
      @(negedge clk_core);
      check_val("flush_ready", ready_o, 1'b0);
      tick(1);
      flush_req = 1'b0;
      valid_i = 1'b0;
      q_a.delete();
      q_b.delete();
      @(negedge clk_core);
      check_val("flush_valid", valid_o, 1'b0);
      check_val("flush_ack", flush_ack, 1'b1);
      tick(1);
      @(negedge clk_core);
      check_val("flush_ack_low", flush_ack, 1'b0);
      ready_mode = 1;
      tick(10);

      // Reset mid-operation discards everything
      ready_mode = 0;
      tick(2);
      drive(3'd5, 32'h500, 32'd7, 32'd3, 32'h20, 1'b0);
      drive(3'd7, 32'h504, 32'd3, 32'd7, 32'h20, 1'b0);
      valid_i = 1'b0;
      rst_core = 1'b1;
      tick(2);
      q_a.delete();
      q_b.delete();
      rst_core = 1'b0;
      @(negedge clk_core);
      check_val("mid_rst_ready", ready_o, 1'b1);
      check_val("mid_rst_valid", valid_o, 1'b0);
      tick(1);
      ready_mode = 1;
      tick(10);
      drive(3'd2, 32'h400, 32'd0, 32'd0, 32'h10, 1'b0);
      valid_i = 1'b0;
      wait_drain();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/hsv_core_branch_pipe.md
HSV_CORE_BRANCH_PIPE -- requirements
Module: hsv_core_branch_pipe

Interface
REQ-001 The block SHALL take parameter XLEN, default 32: operand, PC and target width.
REQ-002 The block SHALL take parameter TAG_W, default 6: width of the instruction tag carried to commit.
REQ-003 The block SHALL take parameter DEPTH, default 4: output FIFO entries; power of two, 2..16.
REQ-004 The block SHALL take parameter ALIGN4, default 1: 1 = targets need 4-byte alignment, 0 = 2-byte alignment.
REQ-005 The block SHALL have port clk_core  in  1: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_core  in  1: reset, synchronous and active-high.
REQ-007 The block SHALL have port flush_req  in  1: discard all in-flight work.
REQ-008 The block SHALL have port flush_ack  out  1: flush completed.
REQ-009 The block SHALL have port valid_i  in  1: input beat valid.
REQ-010 The block SHALL have port ready_o  out  1: block can accept a beat.
REQ-011 The block SHALL have port in_op  in  3: 0 BEQ, 1 BNE, 2 JAL, 3 JALR, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
REQ-012 The block SHALL have ports in_pc, in_rs1, in_rs2, in_imm  in  XLEN each: PC, operands, sign-extended immediate.
REQ-013 The block SHALL have ports in_tag  in  TAG_W and in_pred_taken  in  1: tag and front-end prediction.
REQ-014 The block SHALL have port valid_o  out  1, and port ready_i  in  1: commit side handshake.
REQ-015 The block SHALL have ports out_tag  out  TAG_W and out_link  out  XLEN: tag, and rd write value.
REQ-016 The block SHALL have port out_next_pc  out  XLEN: architecturally correct next PC.
REQ-017 The block SHALL have ports out_mispredict  out  1 and out_exc_misaligned  out  1.

Function
REQ-018 A beat SHALL transfer when valid_i and ready_o are both high, and leave when valid_o and ready_i are both high.
REQ-019 Stage 1 SHALL register the condition and the target; stage 2 SHALL register the commit fields; stage 2 output SHALL then be written into the FIFO.
REQ-020 Minimum latency SHALL be 2 cycles: a beat accepted at edge N appears on valid_o after edge N+2 when the FIFO is empty.
REQ-021 Both stages SHALL always advance; backpressure SHALL be credit-based, with ready_o = !flush_req && (fifo_count + stage valids) < DEPTH.
REQ-022 Branch condition SHALL be: BEQ/BNE equal/not equal; BLT/BGE signed; BLTU/BGEU unsigned; JAL/JALR always taken.
REQ-023 Target SHALL be in_pc+in_imm for branches and JAL, and (in_rs1+in_imm) with bit0 cleared for JALR; all sums are modulo 2^XLEN.
REQ-024 out_next_pc SHALL be target if taken, else in_pc+4 modulo 2^XLEN.
REQ-025 out_link SHALL be in_pc+4 for JAL/JALR and 0 otherwise.
REQ-026 out_exc_misaligned SHALL be 1 iff taken and target[1]=1 with ALIGN4=1, or target[0]=1 with ALIGN4=0 (which JALR cannot trigger).
REQ-027 out_mispredict SHALL be (taken != in_pred_taken), and SHALL be forced to 0 when out_exc_misaligned=1.
REQ-028 The FIFO SHALL keep order; pointers wrap modulo DEPTH; a simultaneous push and pop at full or empty SHALL be legal and keep the count unchanged.
REQ-029 A push when full SHALL be impossible by construction; the bench SHALL assert that it never happens.
REQ-030 Output fields SHALL be stable while valid_o=1 and ready_i=0.
REQ-031 flush_req SHALL, at the same edge, clear both stage valids and empty the FIFO; a beat offered in that cycle SHALL be dropped.
REQ-032 flush_ack SHALL be flush_req registered by one cycle.

Reset
REQ-033 When rst_core=1 at an edge: stage valids and FIFO count SHALL go to 0, valid_o=0, flush_ack=1, and ready_o=0 while rst_core is high.
REQ-034 Reset asserted mid-operation SHALL discard all beats; the first cycle after release SHALL show ready_o=1 and valid_o=0.

Verification
REQ-035 BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> after 2 cycles: next_pc=0x120, mispredict=1, link=0, exc=0.
REQ-036 JALR, rs1=0x1003, imm=0, ALIGN4=1 -> target 0x1002, exc=1, mispredict=0; the same with ALIGN4=0 -> exc=0.
REQ-037 BLT vs BLTU with rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken; pc=0xFFFFFFFC not taken -> next_pc=0.
REQ-038 ready_i=0 with continuous valid_i -> exactly DEPTH beats accepted, then ready_o=0; ready_i=1 -> tags drain in order with no loss.
REQ-039 flush_req with 3 beats in flight -> valid_o=0 the next cycle, flush_ack=1 one cycle after, and no stale beat ever appears.
